// File: rtl/shifter_writeback.sv
// shifter_writeback: MIC-1 shifter, C-bus register writeback, flag latch and MDR memory load
module shifter_writeback #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_n,
  input  logic             alu_z,
  input  logic             sll8,
  input  logic             sra1,
  input  logic [8:0]       c_sel,
  input  logic             cycle_en,
  input  logic             mem_rd_valid,
  input  logic [WIDTH-1:0] mem_rd_data,
  output logic [WIDTH-1:0] c_bus,
  output logic [WIDTH-1:0] h,
  output logic [WIDTH-1:0] opc,
  output logic [WIDTH-1:0] tos,
  output logic [WIDTH-1:0] cpp,
  output logic [WIDTH-1:0] lv,
  output logic [WIDTH-1:0] sp,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] mdr,
  output logic [WIDTH-1:0] mar,
  output logic             n_flag,
  output logic             z_flag,
  output logic             err_shift,
  output logic             err_mdr
);
  logic [WIDTH-1:0] w_c_bus;
  logic [WIDTH-1:0] r_rf [9];
  logic             r_n, r_z, r_err_shift, r_err_mdr;
  always_comb
    w_c_bus = (sll8 & ~sra1) ? {alu_out[WIDTH-9:0], 8'h00} :
              (sra1 & ~sll8) ? {alu_out[WIDTH-1], alu_out[WIDTH-1:1]} : alu_out;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) r_rf[i] <= '0;
      r_n         <= 1'b0;
      r_z         <= 1'b0;
      r_err_shift <= 1'b0;
      r_err_mdr   <= 1'b0;
    end else begin
      for (int i = 0; i < 9; i++)
        if (cycle_en && c_sel[i]) r_rf[i] <= w_c_bus;
      if (mem_rd_valid) r_rf[1] <= mem_rd_data;
      if (cycle_en) begin
        r_n <= alu_n;
        r_z <= alu_z;
      end
      r_err_shift <= cycle_en & sll8 & sra1;
      r_err_mdr   <= mem_rd_valid & cycle_en & c_sel[1];
    end
  end
  assign c_bus     = w_c_bus;
  assign h         = r_rf[8];
  assign opc       = r_rf[7];
  assign tos       = r_rf[6];
  assign cpp       = r_rf[5];
  assign lv        = r_rf[4];
  assign sp        = r_rf[3];
  assign pc        = r_rf[2];
  assign mdr       = r_rf[1];
  assign mar       = r_rf[0];
  assign n_flag    = r_n;
  assign z_flag    = r_z;
  assign err_shift = r_err_shift;
  assign err_mdr   = r_err_mdr;
endmodule

// File: tb/tb_shifter_writeback.sv
// tb_shifter_writeback: directed self-checking bench for shifter_writeback
module tb_shifter_writeback;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] alu_out = '0;
  logic        alu_n = 1'b0;
  logic        alu_z = 1'b0;
  logic        sll8 = 1'b0;
  logic        sra1 = 1'b0;
  logic [8:0]  c_sel = '0;
  logic        cycle_en = 1'b0;
  logic        mem_rd_valid = 1'b0;
  logic [31:0] mem_rd_data = '0;
  logic [31:0] c_bus, h, opc, tos, cpp, lv, sp, pc, mdr, mar;
  logic        n_flag, z_flag, err_shift, err_mdr;
  int          n_cmp = 0;
  int          n_err = 0;
  shifter_writeback #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .alu_out(alu_out), .alu_n(alu_n), .alu_z(alu_z),
    .sll8(sll8), .sra1(sra1), .c_sel(c_sel), .cycle_en(cycle_en),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data), .c_bus(c_bus),
    .h(h), .opc(opc), .tos(tos), .cpp(cpp), .lv(lv), .sp(sp), .pc(pc),
    .mdr(mdr), .mar(mar), .n_flag(n_flag), .z_flag(z_flag),
    .err_shift(err_shift), .err_mdr(err_mdr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    tick;
    tick;
    rst_n = 1'b1;
    tick;
    chk("rst_h", h, 32'h0);
    chk("rst_mdr", mdr, 32'h0);
    chk("rst_flags", {30'h0, n_flag, z_flag}, 32'h0);
    chk("rst_errs", {30'h0, err_shift, err_mdr}, 32'h0);
    // multi-write all nine registers
    alu_out = 32'h1234_5678; c_sel = 9'h1FF; cycle_en = 1'b1; alu_n = 1'b1;
    tick;
    chk("mw_h", h, 32'h1234_5678);
    chk("mw_opc", opc, 32'h1234_5678);
    chk("mw_tos", tos, 32'h1234_5678);
    chk("mw_cpp", cpp, 32'h1234_5678);
    chk("mw_lv", lv, 32'h1234_5678);
    chk("mw_sp", sp, 32'h1234_5678);
    chk("mw_pc", pc, 32'h1234_5678);
    chk("mw_mdr", mdr, 32'h1234_5678);
    chk("mw_mar", mar, 32'h1234_5678);
    chk("mw_n", {31'h0, n_flag}, 32'h1);
    alu_out = 32'h0; c_sel = 9'h004; alu_n = 1'b0; alu_z = 1'b1;
    tick;
    chk("pc_only_pc", pc, 32'h0);
    chk("pc_only_h", h, 32'h1234_5678);
    chk("pc_only_sp", sp, 32'h1234_5678);
    chk("pc_only_mar", mar, 32'h1234_5678);
    chk("pc_only_z", {31'h0, z_flag}, 32'h1);
    // hold with cycle_en low
    cycle_en = 1'b0; c_sel = 9'h1FF; alu_n = 1'b1; alu_z = 1'b0; alu_out = 32'hDEAD_BEEF;
    tick;
    chk("hold_h", h, 32'h1234_5678);
    chk("hold_pc", pc, 32'h0);
    chk("hold_nz", {30'h0, n_flag, z_flag}, 32'h1);
    // shifter
    alu_out = 32'h8000_00F1; sra1 = 1'b1; sll8 = 1'b0; c_sel = 9'h0;
    #1 chk("sra1", c_bus, 32'hC000_0078);
    sra1 = 1'b0; sll8 = 1'b1;
    #1 chk("sll8", c_bus, 32'h0000_F100);
    sra1 = 1'b1;
    #1 chk("both", c_bus, 32'h8000_00F1);
    cycle_en = 1'b1; c_sel = 9'h100; alu_n = 1'b0;
    tick;
    chk("both_h", h, 32'h8000_00F1);
    chk("err_shift_hi", {31'h0, err_shift}, 32'h1);
    cycle_en = 1'b0;
    tick;
    chk("err_shift_lo", {31'h0, err_shift}, 32'h0);
    // flags come from the ALU, not the shifted bus
    alu_out = 32'hFFFF_FFFF; alu_n = 1'b1; alu_z = 1'b0; sra1 = 1'b0; sll8 = 1'b1;
    cycle_en = 1'b1; c_sel = 9'h100;
    tick;
    chk("fl_h", h, 32'hFFFF_FF00);
    chk("fl_nz1", {30'h0, n_flag, z_flag}, 32'h2);
    alu_n = 1'b0; alu_z = 1'b1; sll8 = 1'b0; alu_out = 32'h0;
    tick;
    chk("fl_nz2", {30'h0, n_flag, z_flag}, 32'h1);
    // MDR collision
    mem_rd_data = 32'hAAAA_5555; mem_rd_valid = 1'b1; c_sel = 9'h002; alu_out = 32'h1;
    tick;
    chk("col_mdr", mdr, 32'hAAAA_5555);
    chk("col_err", {31'h0, err_mdr}, 32'h1);
    mem_rd_valid = 1'b0; cycle_en = 1'b0;
    tick;
    chk("col_err_lo", {31'h0, err_mdr}, 32'h0);
    chk("col_mdr_hold", mdr, 32'hAAAA_5555);
    mem_rd_data = 32'h1357_9BDF; mem_rd_valid = 1'b1;
    tick;
    chk("mem_only_mdr", mdr, 32'h1357_9BDF);
    chk("mem_only_err", {31'h0, err_mdr}, 32'h0);
    mem_rd_valid = 1'b0;
    // back-to-back shift errors
    sll8 = 1'b1; sra1 = 1'b1; cycle_en = 1'b1; c_sel = 9'h0;
    tick;
    chk("b2b_1", {31'h0, err_shift}, 32'h1);
    tick;
    chk("b2b_2", {31'h0, err_shift}, 32'h1);
    sll8 = 1'b0; sra1 = 1'b0; cycle_en = 1'b0;
    tick;
    chk("b2b_end", {31'h0, err_shift}, 32'h0);
    // asynchronous reset mid-cycle
    alu_out = 32'h5A5A_A5A5; alu_n = 1'b1; cycle_en = 1'b1; c_sel = 9'h1FF;
    #2 rst_n = 1'b0;
    #1 chk("arst_h", h, 32'h0);
    chk("arst_mdr", mdr, 32'h0);
    chk("arst_nz", {30'h0, n_flag, z_flag}, 32'h0);
    tick;
    chk("arst_hold", tos, 32'h0);
    #2 rst_n = 1'b1;
    tick;
    chk("post_rst_h", h, 32'h5A5A_A5A5);
    chk("post_rst_n", {31'h0, n_flag}, 32'h1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
